// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/2-write register file (r0 = 0) with busy scoreboard, pending count and stall; REGFILE_BYPASS_EN adds write-through forwarding.
// Latency: reads combinational, writes and scoreboard update at posedge; backpressure is the stall output (re & busy), no input is ever dropped.
module regfile_sb #(
  parameter int DWIDTH = 8,
  parameter int RWIDTH = 3,
  parameter int REGNUM = 8,
  parameter int CWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RWIDTH-1:0] ra1,
  input  logic [RWIDTH-1:0] ra2,
  input  logic              re1,
  input  logic              re2,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2,
  input  logic              we_a,
  input  logic [RWIDTH-1:0] wa_a,
  input  logic [DWIDTH-1:0] wd_a,
  input  logic              we_b,
  input  logic [RWIDTH-1:0] wa_b,
  input  logic [DWIDTH-1:0] wd_b,
  input  logic              rsv_en,
  input  logic [RWIDTH-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic              waw_err,
  output logic [CWIDTH-1:0] pend_cnt
);

  localparam logic [RWIDTH:0] NREG = (RWIDTH+1)'(REGNUM);

  logic [DWIDTH-1:0] mem [REGNUM];
  logic [REGNUM-1:0] busy_q;
  logic [REGNUM-1:0] busy_d;
  logic [REGNUM-1:0] wr_a_hit;
  logic [REGNUM-1:0] wr_b_hit;
  logic [REGNUM-1:0] rsv_hit;
  logic [CWIDTH-1:0] pend_d;

  function automatic logic addr_ok(input logic [RWIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG);
  endfunction

  // One-hot decode per register; r0 and out-of-range addresses never hit
  always_comb begin
    wr_a_hit = '0;
    wr_b_hit = '0;
    rsv_hit  = '0;
    for (int i = 1; i < REGNUM; i++) begin
      wr_a_hit[i] = we_a   && (wa_a     == RWIDTH'(i));
      wr_b_hit[i] = we_b   && (wa_b     == RWIDTH'(i));
      rsv_hit[i]  = rsv_en && (rsv_addr == RWIDTH'(i));
    end
  end

  // A new reservation outranks a same-cycle completion on the same register
  always_comb begin
    busy_d = (busy_q & ~wr_b_hit) | rsv_hit;
    pend_d = '0;
    for (int i = 0; i < REGNUM; i++) begin
      pend_d = pend_d + CWIDTH'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REGNUM; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < REGNUM; i++) begin
        if (wr_b_hit[i]) begin
          mem[i] <= wd_b;
        end else if (wr_a_hit[i]) begin
          mem[i] <= wd_a;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= '0;
      pend_cnt <= '0;
      waw_err  <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      pend_cnt <= pend_d;
      if (|(wr_a_hit & busy_q)) begin
        waw_err <= 1'b1;
      end
    end
  end

  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if (addr_ok(ra1)) begin
      rd1   = mem[ra1];
      busy1 = busy_q[ra1];
`ifdef REGFILE_BYPASS_EN
      if (we_a && (wa_a == ra1)) begin
        rd1 = wd_a;
      end
      if (we_b && (wa_b == ra1)) begin
        rd1   = wd_b;
        busy1 = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if (addr_ok(ra2)) begin
      rd2   = mem[ra2];
      busy2 = busy_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (we_a && (wa_a == ra2)) begin
        rd2 = wd_a;
      end
      if (we_b && (wa_b == ra2)) begin
        rd2   = wd_b;
        busy2 = 1'b0;
      end
`endif
    end
  end

  assign stall = (re1 & busy1) | (re2 & busy2);

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
  localparam int DW = 8;
  localparam int RW = 3;
  localparam int RN = 7;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [RW-1:0] ra1 = '0, ra2 = '0, wa_a = '0, wa_b = '0, rsv_addr = '0;
  logic          re1 = 1'b0, re2 = 1'b0, we_a = 1'b0, we_b = 1'b0, rsv_en = 1'b0;
  logic [DW-1:0] wd_a = '0, wd_b = '0;
  logic [DW-1:0] rd1, rd2;
  logic          busy1, busy2, stall, waw_err;
  logic [CW-1:0] pend_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;

  logic [DW-1:0] m_reg  [2**RW];
  bit            m_busy [2**RW];
  bit            m_waw;

  always #5 clk = ~clk;

  regfile_sb #(.DWIDTH(DW), .RWIDTH(RW), .REGNUM(RN), .CWIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ra1(ra1), .ra2(ra2), .re1(re1), .re2(re2), .rd1(rd1), .rd2(rd2),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(busy1), .busy2(busy2), .stall(stall),
    .waw_err(waw_err), .pend_cnt(pend_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ok(input logic [RW-1:0] a);
    return (a != 0) && (int'(a) < RN);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [RW-1:0] a);
    if (!reset_n || !ok(a)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we_b && wa_b == a) return wd_b;
    if (we_a && wa_a == a) return wd_a;
`endif
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input logic [RW-1:0] a);
    if (!reset_n || !ok(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we_b && wa_b == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic int exp_pend();
    int n = 0;
    for (int i = 0; i < 2**RW; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Reference model: later assignments win, so B data and new reservations take priority
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**RW; i++) begin
        m_reg[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
      m_waw <= 1'b0;
    end else begin
      if (we_a && ok(wa_a)) begin
        m_reg[wa_a] <= wd_a;
        if (m_busy[wa_a]) m_waw <= 1'b1;
      end
      if (we_b && ok(wa_b)) begin
        m_reg[wa_b]  <= wd_b;
        m_busy[wa_b] <= 1'b0;
      end
      if (rsv_en && ok(rsv_addr)) m_busy[rsv_addr] <= 1'b1;
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      chk("rd1", rd1, exp_rd(ra1));
      chk("rd2", rd2, exp_rd(ra2));
      chk("busy1", busy1, exp_busy(ra1));
      chk("busy2", busy2, exp_busy(ra2));
      chk("stall", stall, (re1 & exp_busy(ra1)) | (re2 & exp_busy(ra2)));
      chk("waw_err", waw_err, m_waw);
      chk("pend_cnt", pend_cnt, exp_pend());
    end
  end

  task automatic idle();
    we_a = 0; we_b = 0; rsv_en = 0; re1 = 0; re2 = 0;
  endtask

  initial begin
    idle();
    #3;
    chk("reset_pend", pend_cnt, 0);
    chk("reset_waw", waw_err, 0);
    @(negedge clk); reset_n = 1;
    // write r3, then reset between edges
    @(negedge clk); idle(); we_a = 1; wa_a = 3; wd_a = 8'h55;
    @(negedge clk); idle(); ra1 = 3; #3;
    chk("r3_written", rd1, 8'h55);
    #1 reset_n = 0; #1;
    chk("reset_rd1", rd1, 0);
    chk("reset_pend2", pend_cnt, 0);
    chk("reset_waw2", waw_err, 0);
    @(negedge clk); reset_n = 1;
    // r0 write/reserve and out-of-range r7
    @(negedge clk); idle(); we_a = 1; wa_a = 0; wd_a = 8'hFF; rsv_en = 1; rsv_addr = 0;
    we_b = 1; wa_b = 7; wd_b = 8'h99;
    @(negedge clk); idle(); ra1 = 0; ra2 = 7; rsv_en = 1; rsv_addr = 7; #3;
    chk("r0_rd", rd1, 0);
    chk("r0_busy", busy1, 0);
    chk("r0_pend", pend_cnt, 0);
    chk("r7_rd", rd2, 0);
    @(negedge clk); idle(); ra2 = 7; #3;
    chk("r7_busy", busy2, 0);
    chk("r7_pend", pend_cnt, 0);
    // A/B collision
    @(negedge clk); idle(); we_a = 1; we_b = 1; wa_a = 5; wa_b = 5; wd_a = 8'h11; wd_b = 8'h22;
    @(negedge clk); idle(); ra2 = 5; #3;
    chk("collision", rd2, 8'h22);
    // scoreboard
    @(negedge clk); idle(); rsv_en = 1; rsv_addr = 2;
    @(negedge clk); idle(); rsv_en = 1; rsv_addr = 4;
    @(negedge clk); idle(); re1 = 1; ra1 = 2; #3;
    chk("pend_two", pend_cnt, 2);
    chk("busy_r2", busy1, 1);
    chk("stall_r2", stall, 1);
    @(negedge clk); idle(); re1 = 1; ra1 = 2; we_b = 1; wa_b = 2; wd_b = 8'h7A;
    rsv_en = 1; rsv_addr = 6; #3;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_rd", rd1, 8'h7A);
    chk("bypass_busy", busy1, 0);
    chk("bypass_stall", stall, 0);
`else
    chk("nobypass_rd", rd1, 0);
    chk("nobypass_stall", stall, 1);
`endif
    @(negedge clk); idle(); re1 = 1; ra1 = 2; #3;
    chk("pend_net0", pend_cnt, 2);
    chk("r2_data", rd1, 8'h7A);
    chk("r2_free", busy1, 0);
    // reserve and clear r4 together, then WAW from port A
    @(negedge clk); idle(); rsv_en = 1; rsv_addr = 4; we_b = 1; wa_b = 4; wd_b = 8'h44;
    @(negedge clk); idle(); ra1 = 4; #3;
    chk("rsvclr_busy", busy1, 1);
    chk("rsvclr_pend", pend_cnt, 2);
    chk("rsvclr_data", rd1, 8'h44);
    @(negedge clk); idle(); we_a = 1; wa_a = 4; wd_a = 8'h01; #3;
    chk("waw_not_yet", waw_err, 0);
    @(negedge clk); idle(); #3;
    chk("waw_set", waw_err, 1);
    repeat (3) @(negedge clk);
    #3;
    chk("waw_sticky", waw_err, 1);
    // randomized phase with occasional resets
    repeat (3000) begin
      @(negedge clk);
      reset_n  = ($urandom_range(0, 299) != 0);
      ra1      = RW'($urandom_range(0, 7));
      ra2      = RW'($urandom_range(0, 7));
      re1      = $urandom_range(0, 1) == 1;
      re2      = $urandom_range(0, 1) == 1;
      we_a     = $urandom_range(0, 2) == 0;
      wa_a     = RW'($urandom_range(0, 7));
      wd_a     = DW'($urandom);
      we_b     = $urandom_range(0, 2) == 0;
      wa_b     = $urandom_range(0, 3) == 0 ? ra1 : RW'($urandom_range(0, 7));
      wd_b     = DW'($urandom);
      rsv_en   = $urandom_range(0, 2) == 0;
      rsv_addr = $urandom_range(0, 3) == 0 ? wa_b : RW'($urandom_range(0, 7));
    end
    @(negedge clk); idle(); reset_n = 1;
    @(negedge clk); #3;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
